// File: rtl/rx_intf_m_axis_framer_pkg.sv
// Shared definitions for the rx_intf AXI-Stream master framer:
// FSM encodings and the all-ones byte strobe.
package rx_intf_m_axis_framer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } framerState_t;

  // Wide enough for data widths up to 1024 bits; sliced to the real strobe width.
  localparam logic [127:0] TSTRB_ALL_ONES = '1;

endpackage

// File: rtl/rx_intf_m_axis_framer_fifo.sv
// Single-clock first-word-fall-through FIFO: DATAO always shows the head word
// while the FIFO is non-empty; a write while full is ignored.
module fifo64_1clk #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8192,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WREN,
  input  logic                  RDEN,
  input  logic [DATA_WIDTH-1:0] DATAI,
  output logic [DATA_WIDTH-1:0] DATAO,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [CNT_WIDTH-1:0]  data_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wrAddr;
  logic [AW-1:0]         r_rdAddr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_doWrite;
  logic                  w_doRead;

  assign w_doWrite = WREN & ~FULL;
  assign w_doRead  = RDEN & ~EMPTY;

  // Storage has no reset so it maps onto block RAM; only the pointers are flushed.
  always_ff @(posedge CLK) begin
    if (w_doWrite) begin
      r_mem[r_wrAddr] <= DATAI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrAddr <= '0;
      r_rdAddr <= '0;
      r_count  <= '0;
    end else begin
      if (w_doWrite) begin
        r_wrAddr <= r_wrAddr + 1'b1;
      end
      if (w_doRead) begin
        r_rdAddr <= r_rdAddr + 1'b1;
      end
      case ({w_doWrite, w_doRead})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign DATAO      = r_mem[r_rdAddr];
  assign FULL       = (r_count == CNT_WIDTH'(DEPTH));
  assign EMPTY      = (r_count == '0);
  assign data_count = r_count;

endmodule

// File: rtl/rx_intf_m_axis_framer.sv
// AXI-Stream master that drains buffered accelerator words toward the DMA S2MM
// channel, one frame of M_AXIS_NUM_DMA_SYMBOL+1 beats per accepted start pulse.
module rx_intf_m_axis_framer
  import rx_intf_m_axis_framer_pkg::*;
#(
  parameter int MAX_NUM_DMA_SYMBOL     = 8192,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int C_M_AXIS_TDATA_WIDTH   = 64
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                endless_mode,
  input  logic                                start_1trans,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
  input  logic                                DATA_FROM_ACC_VALID,
  output logic                                FULLN_TO_ACC,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   data_count,
  output logic                                fifo_overflow,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST
);

  framerState_t                      r_state;
  framerState_t                      w_nextState;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] r_num;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] r_readPointer;
  logic                              r_frameDone;
  logic                              r_overflow;
  logic                              w_full;
  logic                              w_empty;
  logic                              w_wren;
  logic                              w_tvalid;
  logic                              w_tlast;
  logic                              w_beat;
  logic                              w_startAccepted;

  assign w_wren = DATA_FROM_ACC_VALID & ~w_full;

  fifo64_1clk #(
    .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
    .DEPTH      (MAX_NUM_DMA_SYMBOL),
    .CNT_WIDTH  (MAX_BIT_NUM_DMA_SYMBOL)
  ) u_fifo (
    .CLK        (M_AXIS_ACLK),
    .RST        (M_AXIS_ARESET),
    .WREN       (w_wren),
    .RDEN       (w_beat),
    .DATAI      (DATA_FROM_ACC),
    .DATAO      (M_AXIS_TDATA),
    .FULL       (w_full),
    .EMPTY      (w_empty),
    .data_count (data_count)
  );

  always_comb begin
    w_nextState = r_state;
    w_tvalid    = 1'b0;
    w_tlast     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_1trans) begin
          w_nextState = SEND;
        end
      end
      SEND: begin
        w_tvalid = ~w_empty;
        w_tlast  = w_tvalid & ~endless_mode & (r_readPointer >= r_num);
        if (w_tvalid & M_AXIS_TREADY & w_tlast) begin
          w_nextState = IDLE;
        end
      end
    endcase
  end

  assign w_beat          = w_tvalid & M_AXIS_TREADY;
  assign w_startAccepted = (r_state == IDLE) & start_1trans;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The pointer wraps naturally at its width, which is what endless streaming relies on.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_num         <= '0;
      r_readPointer <= '0;
      r_frameDone   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frameDone <= w_beat & w_tlast;
      if (DATA_FROM_ACC_VALID & w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_startAccepted) begin
        r_num         <= M_AXIS_NUM_DMA_SYMBOL;
        r_readPointer <= '0;
      end else if (w_beat) begin
        r_readPointer <= r_readPointer + 1'b1;
      end
    end
  end

  assign busy          = (r_state == SEND);
  assign frame_done    = r_frameDone;
  assign fifo_overflow = r_overflow;
  assign FULLN_TO_ACC  = ~w_full;
  assign M_AXIS_TVALID = w_tvalid;
  assign M_AXIS_TLAST  = w_tlast;
  assign M_AXIS_TSTRB  = TSTRB_ALL_ONES[C_M_AXIS_TDATA_WIDTH/8-1:0];

endmodule

// File: tb/tb_rx_intf_m_axis_framer.sv
// Scoreboard bench for rx_intf_m_axis_framer: the driver queues every accepted
// word, a negedge monitor pops and checks each beat against the frame rules.
module tb_rx_intf_m_axis_framer;

  localparam int DW    = 64;
  localparam int CW    = 14;
  localparam int DEPTH = 8192;

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic          endlessMode = 1'b0;
  logic          start       = 1'b0;
  logic [CW-1:0] numSym      = '0;
  logic [DW-1:0] dataIn      = '0;
  logic          dataValid   = 1'b0;
  logic          tready      = 1'b0;
  logic          fulln;
  logic [CW-1:0] dataCount;
  logic          overflow;
  logic          busy;
  logic          frameDone;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [7:0]    tstrb;
  logic          tlast;

  always #5 clk = ~clk;

  rx_intf_m_axis_framer dut (
    .M_AXIS_ACLK           (clk),
    .M_AXIS_ARESET         (rst),
    .endless_mode          (endlessMode),
    .start_1trans          (start),
    .M_AXIS_NUM_DMA_SYMBOL (numSym),
    .DATA_FROM_ACC         (dataIn),
    .DATA_FROM_ACC_VALID   (dataValid),
    .FULLN_TO_ACC          (fulln),
    .data_count            (dataCount),
    .fifo_overflow         (overflow),
    .busy                  (busy),
    .frame_done            (frameDone),
    .M_AXIS_TVALID         (tvalid),
    .M_AXIS_TREADY         (tready),
    .M_AXIS_TDATA          (tdata),
    .M_AXIS_TSTRB          (tstrb),
    .M_AXIS_TLAST          (tlast)
  );

  int            checks     = 0;
  int            failures   = 0;
  int            beatsSeen  = 0;
  int unsigned   expNum     = 0;
  int unsigned   frameBeats = 0;
  int            readyMode  = 0;
  logic [DW-1:0] expQ[$];

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Ready pattern: 0 always high, 1 toggling, 2 held low, otherwise random.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      2:       tready = 1'b0;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;
  logic          prevLast  = 1'b0;
  logic          doneExp   = 1'b0;
  logic          expLast;
  logic [DW-1:0] expWord;

  // A frame ends on the beat whose index reaches num; in endless mode it never ends.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
      doneExp   = 1'b0;
    end else begin
      checkOutput("frame_done", frameDone, doneExp);
      if (doneExp) checkOutput("busy_after_done", busy, 0);
      if (prevStall) begin
        checkOutput("tvalid_hold", tvalid, 1);
        checkOutput("tdata_hold", tdata, prevData);
        checkOutput("tlast_hold", tlast, prevLast);
      end
      doneExp = 1'b0;
      if (tvalid && tready) begin
        beatsSeen++;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL beat_without_word: got beat %0h, expected no beat at %0t", tdata, $time);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("tdata", tdata, expWord);
        end
        expLast = !endlessMode && ((frameBeats % 16384) >= expNum);
        checkOutput("tlast", tlast, expLast);
        checkOutput("tstrb", tstrb, 8'hFF);
        frameBeats++;
        doneExp = expLast;
      end
      prevStall = tvalid && !tready;
      prevData  = tdata;
      prevLast  = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word);
    dataIn    = word;
    dataValid = 1'b1;
    expQ.push_back(word);
    tick();
    dataValid = 1'b0;
  endtask

  task automatic startFrame(input int unsigned num);
    numSym     = CW'(num);
    start      = 1'b1;
    expNum     = num;
    frameBeats = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("[TB] FAIL frame_timeout: got busy after %0d cycles, expected idle", budget);
    end
  endtask

  initial begin
    #(10 * 100000);
    $display("[TB] FAIL watchdog: got no finish, expected end within 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("reset_tvalid", tvalid, 0);
    checkOutput("reset_tlast", tlast, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frameDone, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_fulln", fulln, 1);
    checkOutput("reset_count", dataCount, 0);

    $display("[TB] test 1: four prewritten words, num=3");
    readyMode = 0;
    for (int i = 0; i < 4; i++) applyStimulus(64'hA0 + 64'(i));
    b0 = beatsSeen;
    startFrame(3);
    repeat (4) tick();
    checkOutput("t1_beats", 64'(beatsSeen - b0), 4);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_count", dataCount, 0);
    tick();

    $display("[TB] test 2: num=7 with toggling ready");
    for (int i = 0; i < 8; i++) applyStimulus({$urandom, $urandom});
    readyMode = 1;
    startFrame(7);
    waitIdle(100);
    checkOutput("t2_count", dataCount, 0);
    readyMode = 0;
    tick();

    $display("[TB] test 3: empty FIFO, slow producer, num=4");
    b0 = beatsSeen;
    startFrame(4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus({$urandom, $urandom});
      tick();
      tick();
    end
    waitIdle(20);
    checkOutput("t3_beats", 64'(beatsSeen - b0), 5);

    $display("[TB] test 4: num=0 with two words queued");
    readyMode = 2;
    applyStimulus(64'hB0);
    applyStimulus(64'hB1);
    readyMode = 0;
    tick();
    startFrame(0);
    waitIdle(20);
    tick();
    checkOutput("t4_count", dataCount, 1);

    $display("[TB] test 7: random frames, random ready and gaps");
    readyMode = 3;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 12);
      startFrame(n);
      for (int i = 0; i <= n; i++) begin
        applyStimulus({$urandom, $urandom});
        repeat ($urandom_range(0, 2)) tick();
      end
      waitIdle(500);
      tick();
    end
    checkOutput("t7_count", dataCount, 64'(expQ.size()));
    readyMode = 0;
    tick();

    $display("[TB] test 5: endless mode across pointer wrap");
    endlessMode = 1'b1;
    startFrame(3);
    for (int i = 0; i < 20000; i++) applyStimulus({$urandom, $urandom});
    repeat (5) tick();
    checkOutput("t5_busy_endless", busy, 1);
    checkOutput("t5_drained", dataCount, 0);
    endlessMode = 1'b0;
    applyStimulus(64'hC0FFEE);
    repeat (3) tick();
    checkOutput("t5_busy_after_clear", busy, 0);

    $display("[TB] test 6: overflow and reset mid-frame");
    readyMode = 2;
    tick();
    for (int i = 0; i < DEPTH; i++) applyStimulus({$urandom, $urandom});
    checkOutput("t6_fulln", fulln, 0);
    checkOutput("t6_overflow_before", overflow, 0);
    for (int i = 0; i < 2; i++) begin
      dataIn    = 64'hDEAD_0000 + 64'(i);
      dataValid = 1'b1;
      tick();
      dataValid = 1'b0;
    end
    checkOutput("t6_overflow", overflow, 1);
    checkOutput("t6_count_full", dataCount, DEPTH);
    readyMode = 0;
    tick();
    startFrame(DEPTH - 1);
    waitIdle(DEPTH + 100);
    checkOutput("t6_drained", dataCount, 0);
    readyMode = 2;
    for (int i = 0; i < 4; i++) applyStimulus({$urandom, $urandom});
    startFrame(10);
    tick();
    checkOutput("t6_tvalid_stalled", tvalid, 1);
    rst = 1'b1;
    tick();
    expQ.delete();
    checkOutput("t6_reset_tvalid", tvalid, 0);
    checkOutput("t6_reset_busy", busy, 0);
    checkOutput("t6_reset_count", dataCount, 0);
    checkOutput("t6_reset_overflow", overflow, 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
